// File: rtl/psychic5_palette_resp.sv
// rtl/psychic5_palette_resp.sv - dual-bank (TM/OBJ) CPU-writable palette with a two-stage pixel lookup.
// Optional PSYCHIC5_PAL_INTENSITY_EN scales each channel by the entry's intensity nibble.
module psychic5_palette_resp (
   input  logic        i_EMU_MCLK,
   input  logic        i_EMU_MRST,
   input  logic        i_EMU_CLK6MPCEN_n,
   input  logic [13:0] i_ADDR_BUS,
   input  logic [7:0]  i_DATA_WRITE_BUS,
   output logic [7:0]  o_DATA_READ_BUS,
   input  logic        i_CTRL_RD_n,
   input  logic        i_CTRL_WR_n,
   input  logic        i_TM_PALETTE_CS_n,
   input  logic        i_OBJ_PALETTE_CS_n,
   input  logic [7:0]  i_TM_PIXEL,
   input  logic [7:0]  i_OBJ_PIXEL,
   output logic [3:0]  o_VIDEO_R,
   output logic [3:0]  o_VIDEO_G,
   output logic [3:0]  o_VIDEO_B
);

   logic [7:0] tm_mem  [0:511];
   logic [7:0] obj_mem [0:511];

   logic [8:0] cpu_addr;
   logic       one_cs;
   logic       wr_hold;
   logic       wr_edge;
   logic       rd_req;
   logic       unused_addr;

   assign cpu_addr    = i_ADDR_BUS[8:0];
   assign unused_addr = ^i_ADDR_BUS[13:9];
   assign one_cs      = i_TM_PALETTE_CS_n ^ i_OBJ_PALETTE_CS_n;
   assign wr_edge     = one_cs & ~i_CTRL_WR_n & ~wr_hold;
   assign rd_req      = one_cs & ~i_CTRL_RD_n & i_CTRL_WR_n;

   // wr_hold comes out of reset set, so a strobe still low after release never writes.
   always_ff @(posedge i_EMU_MCLK or posedge i_EMU_MRST) begin
      if (i_EMU_MRST) begin
         wr_hold <= 1'b1;
      end else begin
         wr_hold <= ~i_CTRL_WR_n;
      end
   end

   always_ff @(posedge i_EMU_MCLK) begin
      if (wr_edge && !i_EMU_MRST) begin
         if (!i_TM_PALETTE_CS_n) begin
            tm_mem[cpu_addr] <= i_DATA_WRITE_BUS;
         end else begin
            obj_mem[cpu_addr] <= i_DATA_WRITE_BUS;
         end
      end
   end

   always_ff @(posedge i_EMU_MCLK or posedge i_EMU_MRST) begin
      if (i_EMU_MRST) begin
         o_DATA_READ_BUS <= 8'h00;
      end else if (rd_req) begin
         o_DATA_READ_BUS <= i_TM_PALETTE_CS_n ? obj_mem[cpu_addr] : tm_mem[cpu_addr];
      end
   end

   // Video lookup pipeline: stage 1 picks layer/index, stage 2 reads the entry.
   logic       pcen;
   logic       sel_obj;
   logic [7:0] sel_idx;
   logic       s1_valid;
   logic       s1_obj;
   logic [7:0] s1_idx;
   logic [7:0] ent_rg;
   logic [7:0] ent_bi;
   logic [3:0] ch_r;
   logic [3:0] ch_g;
   logic [3:0] ch_b;

   assign pcen    = ~i_EMU_CLK6MPCEN_n;
   assign sel_obj = (i_OBJ_PIXEL[3:0] != 4'hF);
   assign sel_idx = sel_obj ? i_OBJ_PIXEL : i_TM_PIXEL;

   always_ff @(posedge i_EMU_MCLK or posedge i_EMU_MRST) begin
      if (i_EMU_MRST) begin
         s1_valid <= 1'b0;
         s1_obj   <= 1'b0;
         s1_idx   <= 8'h00;
      end else if (pcen) begin
         s1_valid <= 1'b1;
         s1_obj   <= sel_obj;
         s1_idx   <= sel_idx;
      end
   end

   // Asynchronous second read port; sampled at the same edge as a CPU write it sees the old byte.
   assign ent_rg = s1_obj ? obj_mem[{s1_idx, 1'b0}] : tm_mem[{s1_idx, 1'b0}];
   assign ent_bi = s1_obj ? obj_mem[{s1_idx, 1'b1}] : tm_mem[{s1_idx, 1'b1}];

`ifdef PSYCHIC5_PAL_INTENSITY_EN
   function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] i);
      logic [7:0] p;
      p = {4'h0, c} * ({4'h0, i} + 8'd1);
      return 4'(p >> 4);
   endfunction

   assign ch_r = scale(ent_rg[7:4], ent_bi[3:0]);
   assign ch_g = scale(ent_rg[3:0], ent_bi[3:0]);
   assign ch_b = scale(ent_bi[7:4], ent_bi[3:0]);
`else
   logic unused_intensity;

   assign unused_intensity = ^ent_bi[3:0];
   assign ch_r = ent_rg[7:4];
   assign ch_g = ent_rg[3:0];
   assign ch_b = ent_bi[7:4];
`endif

   always_ff @(posedge i_EMU_MCLK or posedge i_EMU_MRST) begin
      if (i_EMU_MRST) begin
         o_VIDEO_R <= 4'h0;
         o_VIDEO_G <= 4'h0;
         o_VIDEO_B <= 4'h0;
      end else if (pcen && s1_valid) begin
         o_VIDEO_R <= ch_r;
         o_VIDEO_G <= ch_g;
         o_VIDEO_B <= ch_b;
      end
   end

endmodule

// File: tb/tb_psychic5_palette_resp.sv
// tb/tb_psychic5_palette_resp.sv - directed self-checking bench for psychic5_palette_resp.
module tb_psychic5_palette_resp;

   logic        clk;
   logic        rst;
   logic        cen_n;
   logic [13:0] addr;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        rd_n;
   logic        wr_n;
   logic        tm_cs_n;
   logic        obj_cs_n;
   logic [7:0]  tm_pix;
   logic [7:0]  obj_pix;
   logic [3:0]  vr;
   logic [3:0]  vg;
   logic [3:0]  vb;

   int checks = 0;
   int errors = 0;
   logic [7:0] rd_val;

   psychic5_palette_resp dut (
      .i_EMU_MCLK         (clk),
      .i_EMU_MRST         (rst),
      .i_EMU_CLK6MPCEN_n  (cen_n),
      .i_ADDR_BUS         (addr),
      .i_DATA_WRITE_BUS   (wdata),
      .o_DATA_READ_BUS    (rdata),
      .i_CTRL_RD_n        (rd_n),
      .i_CTRL_WR_n        (wr_n),
      .i_TM_PALETTE_CS_n  (tm_cs_n),
      .i_OBJ_PALETTE_CS_n (obj_cs_n),
      .i_TM_PIXEL         (tm_pix),
      .i_OBJ_PIXEL        (obj_pix),
      .o_VIDEO_R          (vr),
      .o_VIDEO_G          (vg),
      .o_VIDEO_B          (vb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Data is inverted after the first cycle so a repeated write would be visible.
   task automatic cpu_write(input logic obj, input logic [13:0] a, input logic [7:0] d, input int len);
      @(negedge clk);
      tm_cs_n  = obj;
      obj_cs_n = ~obj;
      addr     = a;
      wdata    = d;
      wr_n     = 1'b0;
      @(negedge clk);
      wdata = ~d;
      repeat (len - 1) @(negedge clk);
      wr_n = 1'b1;
      @(negedge clk);
      tm_cs_n  = 1'b1;
      obj_cs_n = 1'b1;
   endtask

   task automatic cpu_read(input logic obj, input logic [13:0] a, output logic [7:0] d);
      @(negedge clk);
      tm_cs_n  = obj;
      obj_cs_n = ~obj;
      addr     = a;
      rd_n     = 1'b0;
      @(posedge clk);
      #1 d = rdata;
      @(negedge clk);
      rd_n     = 1'b1;
      tm_cs_n  = 1'b1;
      obj_cs_n = 1'b1;
   endtask

   task automatic pix_en();
      @(negedge clk);
      cen_n = 1'b0;
      @(negedge clk);
      cen_n = 1'b1;
   endtask

   initial begin
      rst      = 1'b1;
      cen_n    = 1'b1;
      addr     = 14'h0;
      wdata    = 8'h00;
      rd_n     = 1'b1;
      wr_n     = 1'b1;
      tm_cs_n  = 1'b1;
      obj_cs_n = 1'b1;
      tm_pix   = 8'h00;
      obj_pix  = 8'h0F;

      repeat (3) @(negedge clk);
      check("reset_rdata", {8'h0, rdata}, 16'h0000);
      check("reset_rgb", {4'h0, vr, vg, vb}, 16'h0000);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_reset_rgb", {4'h0, vr, vg, vb}, 16'h0000);

      // TM entry 8, long strobes, upper address bits set on the first write
      cpu_write(1'b0, 14'h2810, 8'hA5, 10);
      cpu_write(1'b0, 14'h0011, 8'h3F, 10);
      tm_pix  = 8'h08;
      obj_pix = 8'h0F;
      pix_en();
      check("first_enable_rgb", {4'h0, vr, vg, vb}, 16'h0000);
      pix_en();
      check("tm_lookup_rgb", {4'h0, vr, vg, vb}, 16'h0A53);
      repeat (5) @(negedge clk);
      check("hold_rgb", {4'h0, vr, vg, vb}, 16'h0A53);

      cpu_write(1'b1, 14'h0010, 8'h12, 3);
      cpu_write(1'b1, 14'h0011, 8'h4F, 3);
      obj_pix = 8'h08;
      pix_en();
      check("latency_old_rgb", {4'h0, vr, vg, vb}, 16'h0A53);
      pix_en();
      check("obj_lookup_rgb", {4'h0, vr, vg, vb}, 16'h0124);
      obj_pix = 8'h1F;
      pix_en();
      pix_en();
      check("obj_transparent_rgb", {4'h0, vr, vg, vb}, 16'h0A53);

      cpu_read(1'b0, 14'h0011, rd_val);
      check("read_tm_011", {8'h0, rd_val}, 16'h003F);
      cpu_read(1'b1, 14'h0010, rd_val);
      check("read_obj_010", {8'h0, rd_val}, 16'h0012);

      // both selects low: neither the write nor the read may take effect
      @(negedge clk);
      tm_cs_n  = 1'b0;
      obj_cs_n = 1'b0;
      addr     = 14'h0010;
      wdata    = 8'h00;
      wr_n     = 1'b0;
      repeat (2) @(negedge clk);
      wr_n = 1'b1;
      rd_n = 1'b0;
      repeat (2) @(negedge clk);
      check("both_cs_read_hold", {8'h0, rdata}, 16'h0012);
      rd_n     = 1'b1;
      tm_cs_n  = 1'b1;
      obj_cs_n = 1'b1;
      cpu_read(1'b0, 14'h0010, rd_val);
      check("both_cs_tm_unchanged", {8'h0, rd_val}, 16'h00A5);
      cpu_read(1'b1, 14'h0010, rd_val);
      check("both_cs_obj_unchanged", {8'h0, rd_val}, 16'h0012);

      // write edge with RD low: write happens, read data untouched
      @(negedge clk);
      tm_cs_n = 1'b0;
      addr    = 14'h0030;
      wdata   = 8'h5A;
      rd_n    = 1'b0;
      wr_n    = 1'b0;
      repeat (2) @(negedge clk);
      check("wr_rd_no_read_update", {8'h0, rdata}, 16'h0012);
      wr_n    = 1'b1;
      rd_n    = 1'b1;
      tm_cs_n = 1'b1;
      cpu_read(1'b0, 14'h0030, rd_val);
      check("wr_rd_write_done", {8'h0, rd_val}, 16'h005A);

      // CPU write and lookup of the same entry on the same MCLK
      @(negedge clk);
      tm_cs_n = 1'b0;
      addr    = 14'h0010;
      wdata   = 8'hB6;
      wr_n    = 1'b0;
      cen_n   = 1'b0;
      @(negedge clk);
      cen_n   = 1'b1;
      wr_n    = 1'b1;
      tm_cs_n = 1'b1;
      check("same_cycle_old_value", {4'h0, vr, vg, vb}, 16'h0A53);
      pix_en();
      check("same_cycle_new_value", {4'h0, vr, vg, vb}, 16'h0B63);
      cpu_write(1'b0, 14'h0010, 8'hA5, 2);

      cpu_write(1'b0, 14'h0040, 8'h8F, 2);
      cpu_write(1'b0, 14'h0041, 8'h47, 2);
      tm_pix  = 8'h20;
      obj_pix = 8'h0F;
      pix_en();
      pix_en();
`ifdef PSYCHIC5_PAL_INTENSITY_EN
      check("intensity_rgb", {4'h0, vr, vg, vb}, 16'h0472);
`else
      check("intensity_rgb", {4'h0, vr, vg, vb}, 16'h08F4);
`endif

      // reset lands on a pending write edge; strobe stays low after release
      @(negedge clk);
      tm_cs_n = 1'b0;
      addr    = 14'h0011;
      wdata   = 8'h77;
      wr_n    = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      check("midstrobe_reset_rdata", {8'h0, rdata}, 16'h0000);
      check("midstrobe_reset_rgb", {4'h0, vr, vg, vb}, 16'h0000);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      wr_n = 1'b1;
      @(negedge clk);
      tm_cs_n = 1'b1;
      cpu_read(1'b0, 14'h0011, rd_val);
      check("reset_cancels_write", {8'h0, rd_val}, 16'h003F);
      pix_en();
      check("reset_clears_pipeline", {4'h0, vr, vg, vb}, 16'h0000);
      cpu_write(1'b0, 14'h0011, 8'h77, 3);
      cpu_read(1'b0, 14'h0011, rd_val);
      check("next_edge_writes", {8'h0, rd_val}, 16'h0077);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
